// File: rtl/stopwatch_lap_if.sv
// Control/status bundle between the stopwatch core and its button/display logic.
// The master side drives the conditioned buttons and configuration; the slave side is the core.
interface stopwatch_lap_if #(
  parameter int CNT_W = 14
);
  logic             btn_clear;
  logic             btn_start;
  logic             btn_stop;
  logic             btn_inc;
  logic             btn_lap;
  logic             mode_down;
  logic [CNT_W-1:0] preset;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] disp_value;
  logic             running;
  logic             lap_valid;
  logic             wrap;
  logic             done;

  modport master (
    output btn_clear, btn_start, btn_stop, btn_inc, btn_lap, mode_down, preset,
    input  count, disp_value, running, lap_valid, wrap, done
  );

  modport slave (
    input  btn_clear, btn_start, btn_stop, btn_inc, btn_lap, mode_down, preset,
    output count, disp_value, running, lap_valid, wrap, done
  );
endinterface

// File: rtl/stopwatch_lap.sv
// Binary stopwatch/timer core: programmable tick, up/down count, manual step, wrap/done pulses.
// Lap capture (freeze display while counting continues) is built only when STOPWATCH_LAP_EN is defined.
module stopwatch_lap #(
  parameter int TICK_DIV  = 100000,
  parameter int CNT_W     = 14,
  parameter int MAX_COUNT = 9999
) (
  input logic            clk,
  input logic            rst,
  stopwatch_lap_if.slave sw
);

  localparam int               DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] MAX_C    = CNT_W'(MAX_COUNT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_LAP  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  function automatic logic [CNT_W-1:0] step_up(input logic [CNT_W-1:0] c);
    return (c >= MAX_C) ? '0 : c + 1'b1;
  endfunction

  function automatic logic [CNT_W-1:0] step_down(input logic [CNT_W-1:0] c);
    return (c == '0) ? '0 : c - 1'b1;
  endfunction

  function automatic logic [CNT_W-1:0] clamp_preset(input logic [CNT_W-1:0] p);
    return (p > MAX_C) ? MAX_C : p;
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             mode_q, mode_d;
  logic             wrap_q, wrap_d;
  logic             done_q, done_d;
  logic [DIV_W-1:0] div_q;
  logic             tick;

  logic btn_clear_q, btn_start_q, btn_stop_q, btn_inc_q;
  logic clear_ev, start_ev, stop_ev, inc_ev;
`ifdef STOPWATCH_LAP_EN
  logic             btn_lap_q;
  logic             lap_ev;
  logic [CNT_W-1:0] lap_reg, lap_d;
`endif

  // Button edge detection: one action per press, held buttons act once
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_clear_q <= 1'b0;
      btn_start_q <= 1'b0;
      btn_stop_q  <= 1'b0;
      btn_inc_q   <= 1'b0;
`ifdef STOPWATCH_LAP_EN
      btn_lap_q   <= 1'b0;
`endif
    end else begin
      btn_clear_q <= sw.btn_clear;
      btn_start_q <= sw.btn_start;
      btn_stop_q  <= sw.btn_stop;
      btn_inc_q   <= sw.btn_inc;
`ifdef STOPWATCH_LAP_EN
      btn_lap_q   <= sw.btn_lap;
`endif
    end
  end

  assign clear_ev = sw.btn_clear & ~btn_clear_q;
  assign start_ev = sw.btn_start & ~btn_start_q;
  assign stop_ev  = sw.btn_stop  & ~btn_stop_q;
  assign inc_ev   = sw.btn_inc   & ~btn_inc_q;
`ifdef STOPWATCH_LAP_EN
  assign lap_ev   = sw.btn_lap   & ~btn_lap_q;
`endif

  // Free-running tick divider; start does not realign it, only clear does
  assign tick = (div_q == DIV_LAST);

  always_ff @(posedge clk) begin
    if (rst || clear_ev) begin
      div_q <= '0;
    end else if (tick) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and next datapath values; only the highest-priority applicable event acts
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    mode_d  = mode_q;
    wrap_d  = 1'b0;
    done_d  = 1'b0;
`ifdef STOPWATCH_LAP_EN
    lap_d   = lap_reg;
`endif
    if (clear_ev) begin
      state_d = S_IDLE;
      mode_d  = sw.mode_down;
      count_d = sw.mode_down ? clamp_preset(sw.preset) : '0;
`ifdef STOPWATCH_LAP_EN
      lap_d   = '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_ev) begin
            if (mode_q && (count_q == '0)) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end else begin
              state_d = S_RUN;
            end
          end else if (inc_ev) begin
            if (mode_q) begin
              count_d = step_down(count_q);
            end else begin
              count_d = step_up(count_q);
              wrap_d  = (count_q == MAX_C);
            end
          end
        end
        S_RUN, S_LAP: begin
          if (stop_ev) begin
            state_d = S_IDLE;
          end
`ifdef STOPWATCH_LAP_EN
          else if (lap_ev) begin
            if (state_q == S_RUN) begin
              state_d = S_LAP;
              lap_d   = count_q;
            end else begin
              state_d = S_RUN;
            end
          end
`endif
          else if (tick) begin
            if (mode_q) begin
              count_d = step_down(count_q);
              if (count_q == CNT_W'(1)) begin
                state_d = S_DONE;
                done_d  = 1'b1;
              end
            end else begin
              count_d = step_up(count_q);
              wrap_d  = (count_q == MAX_C);
            end
          end
        end
        S_DONE: begin
          count_d = '0;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      mode_q  <= 1'b0;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef STOPWATCH_LAP_EN
      lap_reg <= '0;
`endif
    end else begin
      count_q <= count_d;
      mode_q  <= mode_d;
      wrap_q  <= wrap_d;
      done_q  <= done_d;
`ifdef STOPWATCH_LAP_EN
      lap_reg <= lap_d;
`endif
    end
  end

  always_comb begin
    sw.count   = count_q;
    sw.wrap    = wrap_q;
    sw.done    = done_q;
    sw.running = (state_q == S_RUN) || (state_q == S_LAP);
`ifdef STOPWATCH_LAP_EN
    sw.lap_valid  = (state_q == S_LAP);
    sw.disp_value = (state_q == S_LAP) ? lap_reg : count_q;
`else
    sw.lap_valid  = 1'b0;
    sw.disp_value = count_q;
`endif
  end

endmodule

// File: tb/tb_stopwatch_lap.sv
// Bench for stopwatch_lap: directed scenarios plus random button traffic, all checked
// against a cycle-level behavioural model of the stopwatch rules.
module tb_stopwatch_lap;

  localparam int TICK_DIV  = 4;
  localparam int CNT_W     = 4;
  localparam int MAX_COUNT = 9;
`ifdef STOPWATCH_LAP_EN
  localparam bit LAP_EN = 1'b1;
`else
  localparam bit LAP_EN = 1'b0;
`endif

  localparam int ST_IDLE = 0;
  localparam int ST_RUN  = 1;
  localparam int ST_LAP  = 2;
  localparam int ST_DONE = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  stopwatch_lap_if #(.CNT_W(CNT_W)) sw ();

  stopwatch_lap #(
    .TICK_DIV (TICK_DIV),
    .CNT_W    (CNT_W),
    .MAX_COUNT(MAX_COUNT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sw (sw.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc_n    = 0;

  // Model state
  int m_state, m_count, m_lap, m_div, m_mode;
  bit m_wrap, m_done;
  bit pb_clear, pb_start, pb_stop, pb_inc, pb_lap;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc_n);
    end
  endtask

  // Applies the stopwatch rules for one clock edge using the inputs seen at that edge
  task automatic model_step();
    bit clr, st, sp, ic, lp, tick;
    if (rst) begin
      m_state = ST_IDLE; m_count = 0; m_lap = 0; m_div = 0; m_mode = 0;
      m_wrap = 0; m_done = 0;
      {pb_clear, pb_start, pb_stop, pb_inc, pb_lap} = '0;
      return;
    end
    clr = sw.btn_clear && !pb_clear;
    st  = sw.btn_start && !pb_start;
    sp  = sw.btn_stop  && !pb_stop;
    ic  = sw.btn_inc   && !pb_inc;
    lp  = sw.btn_lap   && !pb_lap && LAP_EN;
    {pb_clear, pb_start, pb_stop, pb_inc, pb_lap} =
      {sw.btn_clear, sw.btn_start, sw.btn_stop, sw.btn_inc, sw.btn_lap};
    tick = (m_div == TICK_DIV - 1);
    m_wrap = 0;
    m_done = 0;
    if (clr) begin
      m_state = ST_IDLE;
      m_mode  = int'(sw.mode_down);
      m_count = sw.mode_down ? ((int'(sw.preset) > MAX_COUNT) ? MAX_COUNT : int'(sw.preset)) : 0;
      m_lap   = 0;
      m_div   = 0;
      return;
    end
    m_div = (m_div + 1) % TICK_DIV;
    if (m_state == ST_IDLE) begin
      if (st) begin
        if (m_mode == 1 && m_count == 0) begin
          m_state = ST_DONE;
          m_done  = 1;
        end else begin
          m_state = ST_RUN;
        end
      end else if (ic) begin
        if (m_mode == 1) begin
          if (m_count > 0) m_count--;
        end else begin
          m_wrap  = (m_count == MAX_COUNT);
          m_count = (m_count + 1) % (MAX_COUNT + 1);
        end
      end
    end else if (m_state == ST_RUN || m_state == ST_LAP) begin
      if (sp) begin
        m_state = ST_IDLE;
      end else if (lp) begin
        if (m_state == ST_RUN) begin
          m_lap   = m_count;
          m_state = ST_LAP;
        end else begin
          m_state = ST_RUN;
        end
      end else if (tick) begin
        if (m_mode == 1) begin
          m_count = m_count - 1;
          if (m_count == 0) begin
            m_state = ST_DONE;
            m_done  = 1;
          end
        end else begin
          m_wrap  = (m_count == MAX_COUNT);
          m_count = (m_count + 1) % (MAX_COUNT + 1);
        end
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    cyc_n++;
    check_eq("count",      sw.count,      m_count);
    check_eq("disp_value", sw.disp_value, (m_state == ST_LAP) ? m_lap : m_count);
    check_eq("running",    sw.running,    (m_state == ST_RUN) || (m_state == ST_LAP));
    check_eq("lap_valid",  sw.lap_valid,  m_state == ST_LAP);
    check_eq("wrap",       sw.wrap,       m_wrap);
    check_eq("done",       sw.done,       m_done);
  endtask

  task automatic press_clear(input logic down, input logic [CNT_W-1:0] pre);
    sw.mode_down = down;
    sw.preset    = pre;
    sw.btn_clear = 1'b1;
    cyc();
    sw.btn_clear = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc_n);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int wraps, dones, c_before;
    sw.btn_clear = 0; sw.btn_start = 0; sw.btn_stop = 0; sw.btn_inc = 0; sw.btn_lap = 0;
    sw.mode_down = 0; sw.preset = '0;
    rst = 1'b1;
    cyc();
    check_eq("rst_count", sw.count, 0);
    check_eq("rst_running", sw.running, 0);
    rst = 1'b0;

    // Up count with a single wrap
    press_clear(1'b0, '0);
    cyc();
    sw.btn_start = 1; cyc(); sw.btn_start = 0;
    wraps = 0;
    for (int i = 0; i < 38; i++) begin
      cyc();
      wraps += int'(sw.wrap);
    end
    check_eq("wrap_once", wraps, 1);
    check_eq("count_after_wrap", sw.count, 0);
    check_eq("running_up", sw.running, 1);

    // Stop at 3, then a long-held inc steps only once
    for (int i = 0; i < 40 && sw.count != 3; i++) cyc();
    sw.btn_stop = 1; cyc(); sw.btn_stop = 0;
    check_eq("stopped_count", sw.count, 3);
    check_eq("stopped_running", sw.running, 0);
    sw.btn_inc = 1;
    repeat (20) cyc();
    sw.btn_inc = 0;
    cyc();
    check_eq("held_inc_count", sw.count, 4);

    // Countdown from a clamped preset to DONE
    press_clear(1'b1, 4'd12);
    check_eq("preset_clamped", sw.count, 9);
    sw.mode_down = 0; sw.preset = '0;
    cyc();
    sw.btn_start = 1; cyc(); sw.btn_start = 0;
    dones = 0;
    for (int i = 0; i < 45; i++) begin
      cyc();
      dones += int'(sw.done);
    end
    check_eq("done_once", dones, 1);
    check_eq("down_end_count", sw.count, 0);
    sw.btn_start = 1; cyc(); sw.btn_start = 0;
    sw.btn_inc = 1; cyc(); sw.btn_inc = 0;
    cyc();
    check_eq("done_ignores_start", sw.running, 0);
    check_eq("done_ignores_inc", sw.count, 0);
    press_clear(1'b0, 4'd7);
    check_eq("clear_from_done", sw.count, 0);
    sw.btn_start = 1; cyc(); sw.btn_start = 0;
    check_eq("restart_running", sw.running, 1);

    // Lap capture and release
    for (int i = 0; i < 40 && sw.count != 2; i++) cyc();
    check_eq("reach_count2", sw.count, 2);
    sw.btn_lap = 1; cyc(); sw.btn_lap = 0;
    check_eq("lap_disp", sw.disp_value, 2);
    check_eq("lap_valid_on", sw.lap_valid, LAP_EN);
    for (int i = 0; i < 40 && sw.count != 5; i++) cyc();
    check_eq("reach_count5", sw.count, 5);
    check_eq("lap_frozen", sw.disp_value, LAP_EN ? 2 : 5);
    sw.btn_lap = 1; cyc(); sw.btn_lap = 0;
    check_eq("lap_release_disp", sw.disp_value, 5);
    check_eq("lap_valid_off", sw.lap_valid, 0);

    // Stop coinciding with a tick
    for (int i = 0; i < 10 && m_div != TICK_DIV - 1; i++) cyc();
    c_before = int'(sw.count);
    sw.btn_stop = 1; cyc(); sw.btn_stop = 0;
    check_eq("stop_tick_count", sw.count, c_before);
    check_eq("stop_tick_idle", sw.running, 0);

    // Reset mid-run at 6, then at 9 on a wrapping tick
    press_clear(1'b0, '0);
    sw.btn_start = 1; cyc(); sw.btn_start = 0;
    for (int i = 0; i < 60 && sw.count != 6; i++) cyc();
    check_eq("reach_count6", sw.count, 6);
    for (int i = 0; i < 10 && m_div != TICK_DIV - 1; i++) cyc();
    rst = 1; cyc(); rst = 0;
    check_eq("rst_run_count", sw.count, 0);
    check_eq("rst_run_disp", sw.disp_value, 0);
    check_eq("rst_run_running", sw.running, 0);
    check_eq("rst_run_wrap", sw.wrap, 0);
    check_eq("rst_run_done", sw.done, 0);
    sw.btn_start = 1; cyc(); sw.btn_start = 0;
    for (int i = 0; i < 60 && sw.count != 9; i++) cyc();
    check_eq("reach_count9", sw.count, 9);
    for (int i = 0; i < 10 && m_div != TICK_DIV - 1; i++) cyc();
    rst = 1; cyc(); rst = 0;
    check_eq("rst_wrap_suppressed", sw.wrap, 0);
    check_eq("rst_wrap_count", sw.count, 0);

    // Random button traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 24) == 0) sw.btn_clear = ~sw.btn_clear;
      if ($urandom_range(0, 5)  == 0) sw.btn_start = ~sw.btn_start;
      if ($urandom_range(0, 11) == 0) sw.btn_stop  = ~sw.btn_stop;
      if ($urandom_range(0, 7)  == 0) sw.btn_inc   = ~sw.btn_inc;
      if ($urandom_range(0, 7)  == 0) sw.btn_lap   = ~sw.btn_lap;
      sw.mode_down = 1'($urandom_range(0, 1));
      sw.preset    = CNT_W'($urandom_range(0, 15));
      rst          = ($urandom_range(0, 199) == 0);
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stopwatch_lap.md
# stopwatch_lap

Parametrised stopwatch/timer core, the successor to the fixed 4-digit 1 kHz stopwatch. It counts in binary at a programmable tick rate and adds several features: count-down mode with a preset, lap capture (the display freezes while counting continues), a per-press manual step, and one-cycle wrap/done event pulses. The binary `disp_value` output feeds the existing binary-to-BCD converter and 4-digit display controller; button conditioning (debounce, synchronisation) is upstream.

## Interface
Parameters:
- `TICK_DIV`, 100000: `clk` cycles per count tick (100 MHz → 1 kHz); legal ≥ 2.
- `CNT_W`, 14: counter width.
- `MAX_COUNT`, 9999: highest count value; must be < 2**CNT_W.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `btn_clear`  in  1  clear/reload, level, synchronous to `clk`.
- `btn_start`  in  1  start.
- `btn_stop`  in  1  stop.
- `btn_inc`  in  1  manual single step.
- `btn_lap`  in  1  lap capture/release.
- `mode_down`  in  1  count direction, 1 = down; sampled only on clear.
- `preset`  in  CNT_W  count-down start value; sampled only on clear.
- `count`  out  CNT_W  live counter.
- `disp_value`  out  CNT_W  value to display: the lap register in LAP, otherwise `count`.
- `running`  out  1  high in RUN or LAP.
- `lap_valid`  out  1  high in LAP.
- `wrap`  out  1  one-cycle pulse, up-count wrap MAX_COUNT→0.
- `done`  out  1  one-cycle pulse on entry to DONE.

## Operation
- **Edge detection.** Each `btn_*` input is registered once. The action pulse is `btn & ~btn_q`, so each press acts exactly once.
- **Tick divider.**
  - The divider runs 0..TICK_DIV-1 and `tick` is high on the cycle the divider equals TICK_DIV-1.
  - `rst` and clear zero the divider.
- **Mode register `mode_q`.**
  - Loaded from `mode_down` on clear.
  - Reset value is 0 (up).
- **Priority when events coincide:** rst > clear > stop > start > lap > inc > tick.
- **Clear (any state):**
  - Go to IDLE.
  - `count` = 0 if up; in down mode, `count` = min(preset, MAX_COUNT).
  - Lap register is cleared.
- **IDLE:**
  - start → RUN.
  - inc steps `count` by one: up mode wraps MAX_COUNT→0 and pulses `wrap`; down mode holds at 0, with no `done`.
  - Ticks are ignored.
- **RUN (count on every tick):**
  - Up mode: +1, wrapping MAX_COUNT→0 with a `wrap` pulse.
  - Down mode: -1. If the result is 0, the next state is DONE and `done` pulses.
  - stop → IDLE.
  - lap → LAP, with the current `count` captured into the lap register.
  - In down mode, start with `count` = 0 goes to DONE immediately and pulses `done`.
- **LAP:**
  - Counting continues exactly as in RUN.
  - `disp_value` holds the lap register.
  - lap → RUN (display goes live again).
  - stop → IDLE (display goes live).
  - Reaching 0 in down mode → DONE.
- **DONE:**
  - `count` holds 0.
  - start, stop, lap and inc are ignored.
  - Only clear or `rst` leave DONE.
- **Arithmetic:** modulo within 0..MAX_COUNT only. `count` never exceeds MAX_COUNT.

## Timing
- Reset (`rst` sampled high at a `clk` edge):
  - State = IDLE.
  - `count`, `disp_value`, lap register, divider and `mode_q` = 0.
  - `running`, `lap_valid`, `wrap`, `done` = 0.
  - `btn_*_q` = 0, so a button held high through reset acts once on the first cycle after reset.
- Button latency: an input rising at edge N (sampled 1 where the previous sample was 0) takes effect at edge N, so outputs change after edge N (1-cycle latency).
- Tick latency: `count` updates at the edge where `tick` = 1.
  - In RUN, the first increment occurs TICK_DIV cycles after the last divider zeroing, or earlier if the divider is mid-period: start does not realign the divider.
- start coinciding with tick in IDLE: no count that cycle.
- stop coinciding with tick: stop wins, no count.
- `wrap` and `done` are registered and high for exactly one cycle.
- Reset or clear mid-run aborts at the same edge; no `wrap` or `done` is emitted.

## Configuration
- `STOPWATCH_LAP_EN`:
  - **Defined:** lap capture as described.
  - **Undefined:** LAP state and lap register are not built; `btn_lap` is ignored; `lap_valid` = 0 constant; `disp_value` = `count`.

## Test plan
Bench parameters: TICK_DIV=4, CNT_W=4, MAX_COUNT=9.
- **Up count with wrap:** rst, clear(mode_down=0), start → `count` steps 0,1,…,9,0 every 4 cycles; `wrap` pulses once at 9→0; `running`=1.
- **Stop/step and held button:** start, 3 ticks, stop → `count`=3 holds. inc held high 20 cycles → `count`=4 only.
- **Countdown to done:** clear with mode_down=1, preset=12 → `count`=9 (clamped). start → counts to 0, `done` pulses once, state DONE. start and inc are ignored; clear with mode_down=0 → `count`=0, IDLE.
- **Lap (macro defined):** run to 2, lap → `disp_value`=2 and `lap_valid`=1 while `count` reaches 5. lap → `disp_value`=5 and `lap_valid`=0.
- **Lap (macro undefined):** same stimulus → `disp_value` always equals `count`; `lap_valid`=0.
- **Simultaneous events and reset:** stop and tick on the same edge → `count` unchanged, IDLE. rst asserted mid-RUN at `count`=6 → all outputs 0 the next cycle, no `wrap` or `done`.
